// File: rtl/lcd_text_engine_if.sv
// lcd_text_engine_if: op request handshake plus the byte/strobe/busy link to the LCD controller.
interface lcd_text_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic [7:0] lcd_data;
  logic       lcd_write;
  logic       lcd_cmd_data;
  logic       lcd_busy;
  modport master (output req_valid, req_op, req_data, lcd_busy,
                  input  req_ready, lcd_data, lcd_write, lcd_cmd_data);
  modport slave  (input  req_valid, req_op, req_data, lcd_busy,
                  output req_ready, lcd_data, lcd_write, lcd_cmd_data);
endinterface

// File: rtl/lcd_text_engine.sv
// lcd_text_engine: FIFO-buffered text front-end for an HD44780-class LCD with cursor tracking and line wrap.
// Optional LCD_TEXT_CRLF_EN: CHAR 0x0A/0x0D act as newline/carriage return instead of glyphs.
module lcd_text_engine #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  lcd_text_engine_if.slave                    bus,
  output logic [$clog2(COLS)-1:0]             cursor_col,
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] cursor_row,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                idle
);
  localparam int CW = $clog2(COLS);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_CHAR = 2'd0, OP_SETPOS = 2'd1, OP_CLEAR = 2'd2;
  typedef enum logic [2:0] {IDLE, POP, ADDR, SEND, GUARD, WAIT} state_t;
  state_t          state_q, state_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic [1:0]      op_q, hop;
  logic [7:0]      dat_q, hdat, lcd_data;
  logic [CW-1:0]   col_q, col_d, scol;
  logic [RW-1:0]   row_q, row_d, srow, nrow;
  logic            repos_q, repos_d;
  logic            push, pop, empty, pos_ok, nl, cr, lcd_write, lcd_cmd_data;
  function automatic logic [7:0] addr_of(logic [RW-1:0] r, logic [CW-1:0] c);
    return (r[0] ? 8'h40 : 8'h00) + (32'(r) >= 2 ? 8'(COLS) : 8'h00) + 8'(c);
  endfunction
  assign {hop, hdat}      = mem_q[rp_q];
  assign empty            = cnt_q == '0;
  assign bus.req_ready    = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign push             = bus.req_valid && bus.req_ready;
  assign pop              = state_q == POP;
  assign pos_ok           = 32'(hdat) < COLS * ROWS;
  assign scol             = CW'(32'(dat_q) % COLS);
  assign srow             = RW'(32'(dat_q) / COLS);
  assign nrow             = row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
  assign bus.lcd_data     = lcd_data;
  assign bus.lcd_write    = lcd_write;
  assign bus.lcd_cmd_data = lcd_cmd_data;
  assign cursor_col       = col_q;
  assign cursor_row       = row_q;
  assign fifo_level       = cnt_q;
  assign idle             = empty && state_q == IDLE && !repos_q;
`ifdef LCD_TEXT_CRLF_EN
  assign nl = hop == OP_CHAR && hdat == 8'h0A;
  assign cr = hop == OP_CHAR && hdat == 8'h0D;
`else
  assign nl = 1'b0;
  assign cr = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    repos_d      = repos_q;
    lcd_write    = 1'b0;
    lcd_cmd_data = 1'b0;
    lcd_data     = 8'h00;
    case (state_q)
      IDLE:  state_d = bus.lcd_busy ? IDLE : repos_q ? ADDR : empty ? IDLE : POP;
      POP: begin
        state_d = (hop == OP_SETPOS && !pos_ok) || nl || cr ? IDLE : SEND;
        col_d   = nl || cr ? '0 : col_q;
        row_d   = nl ? nrow : row_q;
        repos_d = repos_q || nl || cr;
      end
      ADDR: begin
        lcd_write = 1'b1;
        lcd_data  = 8'h80 | addr_of(row_q, col_q);
        repos_d   = 1'b0;
        state_d   = GUARD;
      end
      SEND: begin
        lcd_write = 1'b1;
        state_d   = GUARD;
        if (op_q == OP_CHAR) begin
          lcd_cmd_data = 1'b1;
          lcd_data     = dat_q;
          col_d        = col_q == CW'(COLS - 1) ? '0 : col_q + 1'b1;
          row_d        = col_q == CW'(COLS - 1) ? nrow : row_q;
          repos_d      = col_q == CW'(COLS - 1);
        end else if (op_q == OP_SETPOS) begin
          lcd_data = 8'h80 | addr_of(srow, scol);
          col_d    = scol;
          row_d    = srow;
        end else begin
          lcd_data = op_q == OP_CLEAR ? 8'h01 : 8'h02;
          col_d    = '0;
          row_d    = '0;
          repos_d  = 1'b0;
        end
      end
      GUARD:   state_d = WAIT;
      WAIT:    state_d = bus.lcd_busy ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {bus.req_op, bus.req_data};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      repos_q <= 1'b0;
      op_q    <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      repos_q <= repos_d;
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q  <= rp_q + 1'b1;
        op_q  <= hop;
        dat_q <= hdat;
      end
    end
  end
endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: directed checks of write sequence, cursor, wrap, drops, FIFO full, CRLF option and reset.
module tb_lcd_text_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cursor_col;
  logic [0:0] cursor_row;
  logic [3:0] fifo_level;
  logic       idle;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;
  logic [8:0] wlog[$];
  logic [8:0] ex[$];
  lcd_text_engine_if bus();
  lcd_text_engine #(.COLS(16), .ROWS(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .fifo_level(fifo_level), .idle(idle));
  always #5 clk = ~clk;
  assign bus.lcd_busy = hold_busy || busy_cnt != 0;
  // controller model: every strobe keeps busy high for three cycles
  always @(negedge clk) begin
    if (bus.lcd_write) begin
      wlog.push_back({bus.lcd_cmd_data, bus.lcd_data});
      busy_cnt = 3;
    end else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic push(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic settle(input string tag, input logic [3:0] col, input logic row);
    int n = 0;
    while (!(idle && busy_cnt == 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, idle, 1'b1);
    chk({tag, "_nwr"}, wlog.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wlog[i], ex[i]);
    chk({tag, "_col"}, cursor_col, col);
    chk({tag, "_row"}, cursor_row, row);
    wlog.delete();
    ex.delete();
  endtask
  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_level", fifo_level, 0);
    chk("rst_write", bus.lcd_write, 1'b0);
    chk("rst_data", bus.lcd_data, 8'h00);
    chk("rst_cd", bus.lcd_cmd_data, 1'b0);
    chk("rst_cur", {cursor_row, cursor_col}, 5'h00);
    rst_n = 1'b1;
    push(2'd0, 8'h41);
    ex.push_back(9'h141);
    settle("char1", 4'd1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      push(2'd0, 8'h42 + 8'(i));
      ex.push_back(9'h142 + 9'(i));
    end
    ex.push_back(9'h0C0);
    settle("wrap_row0", 4'd0, 1'b1);
    push(2'd1, 8'h13);
    ex.push_back(9'h0C3);
    settle("setpos13", 4'd3, 1'b1);
    push(2'd1, 8'h20);
    settle("setpos_drop", 4'd3, 1'b1);
    push(2'd1, 8'h1F);
    push(2'd0, 8'h5A);
    push(2'd0, 8'h31);
    ex.push_back(9'h0CF);
    ex.push_back(9'h15A);
    ex.push_back(9'h080);
    ex.push_back(9'h131);
    settle("wrap_end", 4'd1, 1'b0);
    push(2'd1, 8'h05);
    push(2'd2, 8'h00);
    ex.push_back(9'h085);
    ex.push_back(9'h001);
    settle("clear", 4'd0, 1'b0);
    push(2'd1, 8'h12);
    push(2'd3, 8'h00);
    ex.push_back(9'h0C2);
    ex.push_back(9'h002);
    settle("home", 4'd0, 1'b0);
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 8'h60 + 8'(i));
      ex.push_back(9'h160 + 9'(i));
    end
    chk("full_ready", bus.req_ready, 1'b0);
    chk("full_level", fifo_level, 8);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_data  = 8'h7F;
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    chk("full_nobypass", fifo_level, 8);
    hold_busy = 1'b0;
    settle("drain", 4'd8, 1'b0);
    push(2'd3, 8'h00);
    ex.push_back(9'h002);
    settle("home2", 4'd0, 1'b0);
    push(2'd0, 8'h41);
    push(2'd0, 8'h0A);
    push(2'd0, 8'h42);
`ifdef LCD_TEXT_CRLF_EN
    ex.push_back(9'h141);
    ex.push_back(9'h0C0);
    ex.push_back(9'h142);
    settle("crlf", 4'd1, 1'b1);
`else
    ex.push_back(9'h141);
    ex.push_back(9'h10A);
    ex.push_back(9'h142);
    settle("crlf", 4'd3, 1'b0);
`endif
    push(2'd0, 8'h55);
    n = 0;
    while (wlog.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rw_strobe", wlog.size(), 1);
    hold_busy = 1'b1;
    push(2'd0, 8'h56);
    push(2'd0, 8'h57);
    chk("rw_level", fifo_level, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_idle", idle, 1'b1);
    chk("rw_level0", fifo_level, 0);
    chk("rw_cur", {cursor_row, cursor_col}, 5'h00);
    chk("rw_write", bus.lcd_write, 1'b0);
    rst_n = 1'b1;
    hold_busy = 1'b0;
    busy_cnt = 0;
    wlog.delete();
    repeat (20) @(negedge clk);
    chk("rw_nowrite", wlog.size(), 0);
    chk("rw_idle2", idle, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
